// File: rtl/rtc_bus_ctrl.sv
// Burst bus master for the external RTC chip: N-byte read/write bursts over a multiplexed address/data bus.
// Optional `RTC_CMD_WRITE_EN appends a CMD_VALUE write to CMD_ADDR after every write burst.
module rtc_bus_ctrl #(
    parameter int         N_REGS    = 3,
    parameter logic [7:0] BASE_ADDR = 8'h23,
    parameter int         T_STROBE  = 5,
    parameter int         T_GAP     = 8,
    parameter logic [7:0] CMD_ADDR  = 8'hF1,
    parameter logic [7:0] CMD_VALUE = 8'h00
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  rw,
    input  logic [8*N_REGS-1:0]   wdata,
    input  logic [7:0]            ad_in,
    output logic [7:0]            ad_out,
    output logic                  ad_oe,
    output logic                  ad,
    output logic                  cs,
    output logic                  wr,
    output logic                  rd,
    output logic [8*N_REGS-1:0]   rdata,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = $clog2((T_STROBE > T_GAP ? T_STROBE : T_GAP) + 8);
    localparam int IW = $clog2(N_REGS + 1);
    localparam logic [CW-1:0] STB_LAST = CW'(T_STROBE - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'((T_GAP > 0) ? T_GAP - 1 : 0);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_REGS - 1);
    localparam logic [IW-1:0] CMD_IDX  = IW'(N_REGS);

    typedef enum logic [4:0] {
        S_IDLE, S_ARM,
        S_A_AD, S_A_CS, S_A_WR, S_A_HOLD, S_A_WRH, S_A_CSH, S_A_ADH, S_A_REL, S_GAP_A,
        S_D_CS, S_D_STB, S_D_HOLD, S_D_STBH, S_D_CSH, S_D_REL, S_GAP_D,
        S_DONE
    } state_t;

    state_t              r_state, w_next;
    logic [CW-1:0]       r_cnt, w_cnt_next;
    logic [IW-1:0]       r_idx;
    logic                r_rw;
    logic [8*N_REGS-1:0] r_wdata, r_rdata;
    logic                w_last, w_adv, w_tx_end;
    logic [7:0]          w_addr, w_wbyte;
    logic [7:0]          r_ad_out, w_out;
    logic                r_ad_oe, r_ad, r_cs, r_wr, r_rd, r_busy, r_done;
    logic                w_oe, w_ad, w_cs, w_wr, w_rd, w_busy, w_done;

    // Index N_REGS is the command slot; it is only ever reached when the command write is built in.
`ifdef RTC_CMD_WRITE_EN
    assign w_last = r_rw ? (r_idx == LAST_IDX) : (r_idx == CMD_IDX);
`else
    assign w_last = (r_idx == LAST_IDX);
`endif
    assign w_addr = (r_idx == CMD_IDX) ? CMD_ADDR : BASE_ADDR - 8'(r_idx);

    always_comb begin
        w_wbyte = CMD_VALUE;
        for (int i = 0; i < N_REGS; i++) begin
            if (r_idx == IW'(i)) w_wbyte = r_wdata[8*i +: 8];
        end
    end

    always_comb begin
        w_next   = r_state;
        w_adv    = 1'b0;
        w_tx_end = 1'b0;
        case (r_state)
            S_IDLE:   if (start) w_next = S_ARM;
            S_ARM:    w_next = S_A_AD;
            S_A_AD:   w_next = S_A_CS;
            S_A_CS:   w_next = S_A_WR;
            S_A_WR:   w_next = S_A_HOLD;
            S_A_HOLD: if (r_cnt == STB_LAST) w_next = S_A_WRH;
            S_A_WRH:  w_next = S_A_CSH;
            S_A_CSH:  w_next = S_A_ADH;
            S_A_ADH:  w_next = S_A_REL;
            S_A_REL:  w_next = (T_GAP == 0) ? S_D_CS : S_GAP_A;
            S_GAP_A:  if (r_cnt == GAP_LAST) w_next = S_D_CS;
            S_D_CS:   w_next = S_D_STB;
            S_D_STB:  w_next = S_D_HOLD;
            S_D_HOLD: if (r_cnt == STB_LAST) w_next = S_D_STBH;
            S_D_STBH: w_next = S_D_CSH;
            S_D_CSH:  w_next = S_D_REL;
            S_D_REL:  if (T_GAP == 0) w_tx_end = 1'b1; else w_next = S_GAP_D;
            S_GAP_D:  if (r_cnt == GAP_LAST) w_tx_end = 1'b1;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (w_tx_end) begin
            if (w_last) begin
                w_next = S_DONE;
            end else begin
                w_next = S_A_AD;
                w_adv  = 1'b1;
            end
        end
    end

    assign w_cnt_next = (w_next == r_state) ? r_cnt + CW'(1) : '0;

    // Pin values are decoded from the next state so every output comes straight from a flop.
    always_comb begin
        w_ad   = 1'b1;
        w_cs   = 1'b1;
        w_wr   = 1'b1;
        w_rd   = 1'b1;
        w_oe   = 1'b1;
        w_out  = 8'hFF;
        w_busy = 1'b1;
        w_done = 1'b0;
        case (w_next)
            S_IDLE:   begin w_oe = 1'b0; w_busy = 1'b0; end
            S_ARM:    w_oe = 1'b0;
            S_DONE:   begin w_oe = 1'b0; w_busy = 1'b0; w_done = 1'b1; end
            S_A_AD:   w_ad = 1'b0;
            S_A_CS:   begin w_ad = 1'b0; w_cs = 1'b0; end
            S_A_WR:   begin w_ad = 1'b0; w_cs = 1'b0; w_wr = 1'b0; end
            S_A_HOLD: begin w_ad = 1'b0; w_cs = 1'b0; w_wr = 1'b0; w_out = w_addr; end
            S_A_WRH:  begin w_ad = 1'b0; w_cs = 1'b0; w_out = w_addr; end
            S_A_CSH:  begin w_ad = 1'b0; w_out = w_addr; end
            S_A_ADH:  w_out = w_addr;
            S_D_CS:   w_cs = 1'b0;
            S_D_STB, S_D_HOLD: begin
                w_cs = 1'b0;
                if (r_rw) begin
                    w_rd = 1'b0;
                    w_oe = 1'b0;
                end else begin
                    w_wr = 1'b0;
                    if (w_next == S_D_HOLD) w_out = w_wbyte;
                end
            end
            S_D_STBH: begin
                w_cs = 1'b0;
                if (r_rw) w_oe = 1'b0; else w_out = w_wbyte;
            end
            S_D_CSH:  if (r_rw) w_oe = 1'b0; else w_out = w_wbyte;
            default:  ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_rw     <= 1'b0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_ad_out <= 8'hFF;
            r_ad_oe  <= 1'b0;
            r_ad     <= 1'b1;
            r_cs     <= 1'b1;
            r_wr     <= 1'b1;
            r_rd     <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (r_state == S_IDLE && start) begin
                r_rw    <= rw;
                r_wdata <= wdata;
                r_idx   <= '0;
            end else if (w_adv) begin
                r_idx <= r_idx + IW'(1);
            end
            // Read data is taken on the edge that raises rd, while the chip still drives the bus.
            if (w_next == S_D_STBH && r_rw) begin
                for (int i = 0; i < N_REGS; i++) begin
                    if (r_idx == IW'(i)) r_rdata[8*i +: 8] <= ad_in;
                end
            end
            r_ad_out <= w_out;
            r_ad_oe  <= w_oe;
            r_ad     <= w_ad;
            r_cs     <= w_cs;
            r_wr     <= w_wr;
            r_rd     <= w_rd;
            r_busy   <= w_busy;
            r_done   <= w_done;
        end
    end

    assign ad_out = r_ad_out;
    assign ad_oe  = r_ad_oe;
    assign ad     = r_ad;
    assign cs     = r_cs;
    assign wr     = r_wr;
    assign rd     = r_rd;
    assign rdata  = r_rdata;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Self-checking bench for rtc_bus_ctrl: two instances (default and N_REGS=16/T_STROBE=1/T_GAP=0/BASE 05)
// compared cycle by cycle against a timing-table model, with a chip model answering reads.
module tb_rtc_bus_ctrl;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         rw = 1'b0;
    logic         sel = 1'b0;
    logic [127:0] wdataAll = '0;
    logic [7:0]   adIn = 8'h00;

    int assertCount = 0;
    int failCount = 0;

    logic [7:0]   resp [16];
    logic [127:0] expRdata [2];
    int           ridx = 0;
    logic         prevRd = 1'b1;

    logic [7:0]   adOut0, adOut1;
    logic         adOe0, ad0, cs0, wr0, rd0, busy0, done0;
    logic         adOe1, ad1, cs1, wr1, rd1, busy1, done1;
    logic [23:0]  rdata0;
    logic [127:0] rdata1;
    logic [14:0]  obs;
    logic [127:0] obsRdata;

    always #5 clock = ~clock;

    rtc_bus_ctrl dut0 (
        .clock(clock), .reset(reset), .start(start & ~sel), .rw(rw), .wdata(wdataAll[23:0]),
        .ad_in(adIn), .ad_out(adOut0), .ad_oe(adOe0), .ad(ad0), .cs(cs0), .wr(wr0), .rd(rd0),
        .rdata(rdata0), .busy(busy0), .done(done0)
    );

    rtc_bus_ctrl #(.N_REGS(16), .BASE_ADDR(8'h05), .T_STROBE(1), .T_GAP(0)) dut1 (
        .clock(clock), .reset(reset), .start(start & sel), .rw(rw), .wdata(wdataAll),
        .ad_in(adIn), .ad_out(adOut1), .ad_oe(adOe1), .ad(ad1), .cs(cs1), .wr(wr1), .rd(rd1),
        .rdata(rdata1), .busy(busy1), .done(done1)
    );

    assign obs = sel ? {busy1, done1, ad1, cs1, wr1, rd1, adOe1, adOut1}
                     : {busy0, done0, ad0, cs0, wr0, rd0, adOe0, adOut0};
    assign obsRdata = sel ? rdata1 : {104'b0, rdata0};

    // Chip model: drives the queued response while rd is low, junk otherwise.
    always @(negedge clock) begin
        if (!obs[14]) ridx = 0;
        else if (!prevRd && obs[9]) ridx = ridx + 1;
        adIn = (!obs[9] && ridx < 16) ? resp[ridx] : 8'($urandom);
        prevRd = obs[9];
    end

    // Expected pins k edges after acceptance, taken directly from the per-transaction edge table.
    function automatic logic [14:0] expOut(input int k, input int n, input int base, input int ts,
                                           input int tg, input bit rwm, input logic [127:0] wd);
        int L, nt, j, t, o, p;
        logic busyE, doneE, adE, csE, wrE, rdE, oeE;
        logic [7:0] outE, addr, data;
        L = 12 + 2*ts + 2*tg;
        nt = n;
`ifdef RTC_CMD_WRITE_EN
        if (!rwm) nt = n + 1;
`endif
        busyE = 1'b0; doneE = 1'b0; adE = 1'b1; csE = 1'b1; wrE = 1'b1; rdE = 1'b1;
        oeE = 1'b0; outE = 8'hFF;
        if (k == 0) begin
            busyE = 1'b1;
        end else begin
            j = k - 1;
            t = j / L;
            o = j % L;
            if (t < nt) begin
                busyE = 1'b1;
                oeE = 1'b1;
                addr = (t == n) ? 8'hF1 : 8'(base - t);
                data = (t == n) ? 8'h00 : wd[8*t +: 8];
                if (o < 7 + ts) begin
                    adE = !(o <= 4 + ts);
                    csE = !(o >= 1 && o <= 3 + ts);
                    wrE = !(o >= 2 && o <= 2 + ts);
                    if (o >= 3 && o <= 5 + ts) outE = addr;
                end
                p = o - (7 + ts + tg);
                if (p >= 0 && p < 5 + ts) begin
                    csE = !(p <= 2 + ts);
                    if (p >= 1 && p <= 1 + ts) begin
                        if (rwm) rdE = 1'b0; else wrE = 1'b0;
                    end
                    if (!rwm && p >= 2 && p <= 3 + ts) outE = data;
                    if (rwm && p >= 1 && p <= 3 + ts) oeE = 1'b0;
                end
            end else if (t == nt && o == 0) begin
                doneE = 1'b1;
            end
        end
        return {busyE, doneE, adE, csE, wrE, rdE, oeE, outE};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit s, input bit rwIn, input logic [127:0] wd, input bit noisy);
        int n, base, ts, tg, L, nt, total;
        n = s ? 16 : 3;
        base = s ? 8'h05 : 8'h23;
        ts = s ? 1 : 5;
        tg = s ? 0 : 8;
        L = 12 + 2*ts + 2*tg;
        nt = n;
`ifdef RTC_CMD_WRITE_EN
        if (!rwIn) nt = n + 1;
`endif
        total = 1 + nt * L;
        @(negedge clock);
        sel = s;
        rw = rwIn;
        wdataAll = wd;
        start = 1'b1;
        @(posedge clock);
        for (int k = 0; k <= total + 2; k++) begin
            @(negedge clock);
            if (k < total) start = noisy && ($urandom_range(0, 3) == 0);
            else start = (k == total) && noisy;
            if (noisy) begin
                rw = 1'($urandom);
                wdataAll = {$urandom, $urandom, $urandom, $urandom};
            end
            checkOutput($sformatf("pins dut%0d rw=%0d k=%0d", s, rwIn, k), 128'(obs),
                        128'(expOut(k, n, base, ts, tg, rwIn, wd)));
            checkOutput($sformatf("wr_rd_exclusive dut%0d k=%0d", s, k), 128'(obs[10] | obs[9]), 128'(1'b1));
        end
        start = 1'b0;
        if (rwIn) begin
            for (int i = 0; i < n; i++) expRdata[s][8*i +: 8] = resp[i];
        end
        checkOutput($sformatf("rdata dut%0d rw=%0d", s, rwIn), obsRdata, expRdata[s]);
    endtask

    task automatic fillResp();
        for (int i = 0; i < 16; i++) resp[i] = 8'($urandom);
    endtask

    initial begin
        expRdata[0] = '0;
        expRdata[1] = '0;
        fillResp();

        #2 reset = 1'b1;
        #1;
        checkOutput("reset pins dut0", 128'({busy0, done0, ad0, cs0, wr0, rd0, adOe0, adOut0}), 128'(15'h1EFF));
        checkOutput("reset pins dut1", 128'({busy1, done1, ad1, cs1, wr1, rd1, adOe1, adOut1}), 128'(15'h1EFF));
        checkOutput("reset rdata dut0", 128'(rdata0), '0);
        checkOutput("reset rdata dut1", rdata1, '0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        applyStimulus(1'b0, 1'b0, 128'h305912, 1'b0);
        applyStimulus(1'b0, 1'b0, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        fillResp();
        resp[0] = 8'hA5;
        resp[1] = 8'h3C;
        applyStimulus(1'b0, 1'b1, '0, 1'b1);
        applyStimulus(1'b1, 1'b0, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        fillResp();
        applyStimulus(1'b1, 1'b1, '0, 1'b0);

        // Abandon a read burst part-way through with a mid-cycle reset.
        fillResp();
        @(negedge clock);
        sel = 1'b0;
        rw = 1'b1;
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (59) @(negedge clock);
        checkOutput("partial rdata byte0", 128'(rdata0[7:0]), 128'(resp[0]));
        #2 reset = 1'b1;
        #1;
        checkOutput("midburst reset pins", 128'(obs), 128'(15'h1EFF));
        checkOutput("midburst reset rdata", 128'(rdata0), '0);
        expRdata[0] = '0;
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("idle after reset", 128'(obs), 128'(15'h1EFF));

        applyStimulus(1'b0, 1'b0, {$urandom, $urandom, $urandom, $urandom}, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
